// File: rtl/ac_scan_engine.sv
// Aho-Corasick scan engine: walks the external transition table one payload
// byte at a time and reports accept-state hits with their byte offset.
module ac_scan_engine #(
    parameter int OFFSET_W = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic [17:0]         lut_req,
    input  logic [9:0]          lut_data,
    input  logic                lut_nvalid,
    output logic [7:0]          acc_state,
    input  logic                acc_hit,
    output logic                match_valid,
    output logic [7:0]          match_state,
    output logic [OFFSET_W-1:0] match_offset,
    output logic [CNT_W-1:0]    match_count
);

    typedef enum logic [1:0] {IDLE, LOOK, ROOT} state_t;

    state_t              state_q;
    logic [7:0]          cur_state_q;
    logic [7:0]          ch_q;
    logic                last_q;
    logic [OFFSET_W-1:0] offset_q;
    logic                upd_q;
    logic                match_valid_q;
    logic [7:0]          match_state_q;
    logic [OFFSET_W-1:0] match_offset_q;
    logic [CNT_W-1:0]    match_count_q;

    // Upper table bits carry no state information.
    logic unused_lut_hi;
    assign unused_lut_hi = ^lut_data[9:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cur_state_q    <= '0;
            ch_q           <= '0;
            last_q         <= 1'b0;
            offset_q       <= '0;
            upd_q          <= 1'b0;
            match_valid_q  <= 1'b0;
            match_state_q  <= '0;
            match_offset_q <= '0;
            match_count_q  <= '0;
        end else begin
            match_valid_q <= 1'b0;

            // upd is only ever set on the way into IDLE, so these writes to
            // cur_state never collide with the LOOK/ROOT writes below.
            if (upd_q) begin
                upd_q <= 1'b0;
                if (acc_hit) begin
                    match_valid_q  <= 1'b1;
                    match_state_q  <= cur_state_q;
                    match_offset_q <= offset_q;
                    if (match_count_q != '1) begin
                        match_count_q <= match_count_q + CNT_W'(1);
                    end
                end
                if (last_q) begin
                    offset_q    <= '0;
                    cur_state_q <= '0;
                end else begin
                    offset_q <= offset_q + OFFSET_W'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ch_q    <= in_data;
                        last_q  <= in_last;
                        state_q <= LOOK;
                    end
                end
                LOOK: begin
                    if (!lut_nvalid) begin
                        cur_state_q <= lut_data[7:0];
                        upd_q       <= 1'b1;
                        state_q     <= IDLE;
                    end else if (cur_state_q != 8'h00) begin
                        state_q <= ROOT;
                    end else begin
                        upd_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                ROOT: begin
                    cur_state_q <= lut_nvalid ? 8'h00 : lut_data[7:0];
                    upd_q       <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        lut_req = '0;
        case (state_q)
            IDLE:    lut_req = {2'b00, cur_state_q, 8'h00};
            LOOK:    lut_req = {2'b00, cur_state_q, ch_q};
            ROOT:    lut_req = {2'b00, 8'h00, ch_q};
            default: lut_req = '0;
        endcase
    end

    assign in_ready     = (state_q == IDLE);
    assign acc_state    = cur_state_q;
    assign match_valid  = match_valid_q;
    assign match_state  = match_state_q;
    assign match_offset = match_offset_q;
    assign match_count  = match_count_q;

endmodule

// File: tb/tb_ac_scan_engine.sv
// Scoreboard bench for ac_scan_engine: a string-level automaton model predicts
// matches per accepted byte; a monitor compares them as match_valid pulses.
module tb_ac_scan_engine;

    localparam int OFFSET_W = 16;
    localparam int CNT_W    = 4;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_last;
    logic                in_ready;
    logic [17:0]         lut_req;
    logic [9:0]          lut_data;
    logic                lut_nvalid;
    logic [7:0]          acc_state;
    logic                acc_hit;
    logic                match_valid;
    logic [7:0]          match_state;
    logic [OFFSET_W-1:0] match_offset;
    logic [CNT_W-1:0]    match_count;

    ac_scan_engine #(.OFFSET_W(OFFSET_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .lut_req(lut_req), .lut_data(lut_data), .lut_nvalid(lut_nvalid),
        .acc_state(acc_state), .acc_hit(acc_hit),
        .match_valid(match_valid), .match_state(match_state),
        .match_offset(match_offset), .match_count(match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transition table: chain over "abcdefgh"; misses return garbage next-state.
    string PAT = "abcdefgh";
    logic [255:0] acc_mask;
    logic [9:0]   junk;
    logic [7:0]   req_s, req_c;
    logic         hit_w;

    initial junk = '0;
    always @(posedge clk) junk = 10'($urandom);

    assign req_s      = lut_req[15:8];
    assign req_c      = lut_req[7:0];
    assign hit_w      = (req_s < 8'd8) && (req_c == 8'h61 + req_s);
    assign lut_nvalid = !hit_w;
    assign lut_data   = {junk[9:8], hit_w ? req_s + 8'd1 : junk[7:0]};
    assign acc_hit    = acc_mask[acc_state];

    // Reference model
    typedef struct {
        int st;
        int off;
        int cnt;
    } exp_t;
    exp_t q[$];
    int m_state = 0;
    int m_off   = 0;
    int m_cnt   = 0;

    function automatic int goto_fn(input int s, input int c);
        if (s < 8 && c == int'(PAT[s])) return s + 1;
        return -1;
    endfunction

    task automatic model_byte(input int c, input bit last);
        int n;
        n = goto_fn(m_state, c);
        if (n < 0 && m_state != 0) n = goto_fn(0, c);
        if (n < 0) n = 0;
        if (acc_mask[n]) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            q.push_back('{st: n, off: m_off, cnt: m_cnt});
        end
        if (last) begin
            m_state = 0;
            m_off   = 0;
        end else begin
            m_state = n;
            m_off   = (m_off + 1) % (1 << OFFSET_W);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("lut_req_hi", 32'(lut_req[17:16]), 32'd0);
            if (match_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_match: got state=%0d offset=%0d, expected no match",
                             match_state, match_offset);
                end else begin
                    e = q.pop_front();
                    chk("match_state", 32'(match_state), e.st);
                    chk("match_offset", 32'(match_offset), e.off);
                    chk("match_count", 32'(match_count), e.cnt);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] c, input bit last);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = c;
        in_last  = last;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 20 cycles");
        end else begin
            @(posedge clk);
            model_byte(int'(c), last);
        end
    endtask

    task automatic send_str(input string s, input bit last_at_end);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], last_at_end && (i == s.len() - 1));
        end
    endtask

    task automatic settle(input string name);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk(name, 32'(acc_state), m_state);
    endtask

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [7:0] c;
        int gap;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        acc_mask = '0;
        acc_mask[8] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_lut_req", 32'(lut_req), 32'd0);
        chk("rst_acc_state", 32'(acc_state), 32'd0);
        chk("rst_match_valid", 32'(match_valid), 32'd0);
        chk("rst_match_count", 32'(match_count), 32'd0);
        rst = 1'b0;

        // Full pattern in one packet
        send_str("abcdefgh", 1'b1);
        settle("state_after_match");

        // Double miss: LOOK and ROOT both fail
        send_str("ab", 1'b0);
        send_byte("z", 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("abz_look_ready", 32'(in_ready), 32'd0);
        chk("abz_look_req", 32'(lut_req), 32'h0027A);
        @(negedge clk);
        chk("abz_root_ready", 32'(in_ready), 32'd0);
        chk("abz_root_req", 32'(lut_req), 32'h0007A);
        @(negedge clk);
        chk("abz_ready_back", 32'(in_ready), 32'd1);
        settle("abz_state");

        // Miss then root retry hit
        send_str("ab", 1'b0);
        send_byte("a", 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("aba_look_req", 32'(lut_req), 32'h00261);
        @(negedge clk);
        chk("aba_root_req", 32'(lut_req), 32'h00061);
        settle("aba_state");
        send_byte("z", 1'b1);
        settle("flush_state");

        // Back-to-back packets with in_valid held high
        send_str("abcdefgh", 1'b1);
        send_byte("a", 1'b0);
        @(negedge clk);
        chk("b2b_first_look", 32'(lut_req), 32'h00061);
        send_str("bcdefgh", 1'b1);
        settle("b2b_state");

        // Counter saturation
        repeat (17) send_str("abcdefgh", 1'b1);
        settle("sat_state");
        chk("sat_count", 32'(match_count), 32'd15);
        chk("sat_queue_empty", q.size(), 32'd0);

        // Reset while in ROOT
        send_byte("a", 1'b0);
        send_byte("z", 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rr_look_req", 32'(lut_req), 32'h0017A);
        @(negedge clk);
        chk("rr_root_req", 32'(lut_req), 32'h0007A);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_state = 0;
        m_off   = 0;
        m_cnt   = 0;
        chk("rr_in_ready", 32'(in_ready), 32'd1);
        chk("rr_lut_req", 32'(lut_req), 32'd0);
        chk("rr_acc_state", 32'(acc_state), 32'd0);
        chk("rr_match_valid", 32'(match_valid), 32'd0);
        chk("rr_match_state", 32'(match_state), 32'd0);
        chk("rr_match_offset", 32'(match_offset), 32'd0);
        chk("rr_match_count", 32'(match_count), 32'd0);
        @(negedge clk);
        chk("rr_no_pulse", 32'(match_valid), 32'd0);

        // Randomized traffic with several accepting states
        acc_mask    = '0;
        acc_mask[2] = 1'b1;
        acc_mask[5] = 1'b1;
        acc_mask[8] = 1'b1;
        for (int i = 0; i < 400; i++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
            if ($urandom_range(0, 9) < 7 && m_state < 8) begin
                c = PAT[m_state];
            end else if ($urandom_range(0, 8) == 8) begin
                c = "z";
            end else begin
                c = PAT[$urandom_range(0, 7)];
            end
            send_byte(c, $urandom_range(0, 9) == 0);
        end
        settle("rand_state");
        chk("rand_count", 32'(match_count), m_cnt);
        chk("rand_queue_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
